// File: rtl/axis_stall_detector.sv
// axis_stall_detector: watches the tvalid/tready pairs of several AXI-Stream
// channels and raises a debounced per-channel "blocked" flag after THRESH
// consecutive stall cycles. It also reports the cause of each block and
// latches the lowest-index channel that blocked first.
// Optional macro AXIS_STALL_CNT_EN adds a 16-bit saturating stall-cycle
// counter per channel. The counters are read through cnt_sel/cnt_rd.
module axis_stall_detector #(
    parameter int              N_CH     = 2,
    parameter int              THRESH   = 16,
    parameter logic [N_CH-1:0] DIR_MASK = N_CH'(2'b01),
    parameter int              IDX_W    = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_CH-1:0]     ch_tvalid,
    input  logic [N_CH-1:0]     ch_tready,
    input  logic                clear_sticky,
`ifdef AXIS_STALL_CNT_EN
    input  logic [IDX_W-1:0]    cnt_sel,
    output logic [15:0]         cnt_rd,
`endif
    output logic [N_CH-1:0]     axis_block_sigs,
    output logic [2*N_CH-1:0]   axis_block_info,
    output logic                any_block,
    output logic                first_valid,
    output logic [IDX_W-1:0]    first_idx
);

    localparam int CNT_W = $clog2(THRESH + 1);

    typedef enum logic [1:0] {RUN, PEND, BLOCKED} state_t;

    state_t             state_q [N_CH];
    state_t             state_d [N_CH];
    logic [CNT_W-1:0]   cnt_q   [N_CH];
    logic [CNT_W-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0]    stall;
    logic [N_CH-1:0]    entering;
    logic [N_CH-1:0]    flag_d;
    logic [N_CH-1:0]    flag_q;
    logic [2*N_CH-1:0]  info_d;
    logic [2*N_CH-1:0]  info_q;
    logic               first_valid_d;
    logic               first_valid_q;
    logic [IDX_W-1:0]   first_idx_d;
    logic [IDX_W-1:0]   first_idx_q;
    logic [IDX_W-1:0]   first_pick;

    // Per-channel stall detection and RUN/PEND/BLOCKED next-state logic.
    // The count is parked at THRESH while BLOCKED, so it never re-triggers an entry.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            stall[i]    = DIR_MASK[i] ? (ch_tready[i] & ~ch_tvalid[i])
                                      : (ch_tvalid[i] & ~ch_tready[i]);
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            entering[i] = 1'b0;
            if (!stall[i]) begin
                state_d[i] = RUN;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    BLOCKED: begin
                        state_d[i] = BLOCKED;
                    end
                    default: begin
                        if (cnt_q[i] == CNT_W'(THRESH - 1)) begin
                            state_d[i]  = BLOCKED;
                            cnt_d[i]    = CNT_W'(THRESH);
                            entering[i] = 1'b1;
                        end else begin
                            state_d[i] = PEND;
                            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                        end
                    end
                endcase
            end
            flag_d[i]         = (state_d[i] == BLOCKED);
            info_d[2*i +: 2]  = flag_d[i] ? (DIR_MASK[i] ? 2'b01 : 2'b10) : 2'b00;
        end
    end

    // The first-block latch picks the lowest entering index. A clear that arrives on the same edge as a new entry keeps the latch set.
    always_comb begin
        first_pick = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (entering[i]) begin
                first_pick = IDX_W'(i);
            end
        end
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if ((|entering) && (!first_valid_q || clear_sticky)) begin
            first_valid_d = 1'b1;
            first_idx_d   = first_pick;
        end else if (clear_sticky) begin
            first_valid_d = 1'b0;
            first_idx_d   = '0;
        end
    end

    // State, counters, flags, cause info and the first-block latch are all registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= RUN;
                cnt_q[i]   <= '0;
            end
            flag_q        <= '0;
            info_q        <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            flag_q        <= flag_d;
            info_q        <= info_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
        end
    end

    assign axis_block_sigs = flag_q;
    assign axis_block_info = info_q;
    assign any_block       = |flag_q;
    assign first_valid     = first_valid_q;
    assign first_idx       = first_idx_q;

`ifdef AXIS_STALL_CNT_EN
    logic [15:0] total_q [N_CH];
    logic [15:0] rd_d;

    // Total stall-cycle counters saturate at 16'hFFFF. Transfers do not clear them. Only reset or clear_sticky does.
    always_ff @(posedge clock) begin
        if (reset || clear_sticky) begin
            for (int i = 0; i < N_CH; i++) begin
                total_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (stall[i] && (total_q[i] != 16'hFFFF)) begin
                    total_q[i] <= total_q[i] + 16'd1;
                end
            end
        end
    end

    // Read mux. A select that matches no channel returns zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_sel == IDX_W'(i)) begin
                rd_d = total_q[i];
            end
        end
    end

    // Register the selected counter so that a read takes one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_rd <= '0;
        end else begin
            cnt_rd <= rd_d;
        end
    end
`endif

endmodule
